// File: rtl/vpu_timing_cntr_bank.sv
// vpu_timing_cntr_bank: bank of NUM_CH saturating down-counters for scheduler timing constraints.
// Each channel accepts addressed or broadcast loads, in overwrite or max-merge mode.
// The bank also provides a global freeze and a synchronous clear, and reports per-channel
// ready/expiry plus an aggregate busy flag.
// Optional feature macro: VPU_TCB_EARLY_ZERO_EN adds ready_n_o, the next-state zero flag.
module vpu_timing_cntr_bank #(
   parameter int unsigned NUM_CH     = 8,
   parameter int unsigned CNTR_WIDTH = 4,
   parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_valid_i,
   input  logic                  load_bcast_i,
   input  logic [CH_W-1:0]       load_ch_i,
   input  logic [CNTR_WIDTH-1:0] load_value_i,
   input  logic                  load_max_i,
   input  logic                  freeze_i,
   input  logic                  clear_i,
`ifdef VPU_TCB_EARLY_ZERO_EN
   output logic [NUM_CH-1:0]     ready_n_o,
`endif
   output logic [NUM_CH-1:0]     ready_o,
   output logic                  busy_o,
   output logic [NUM_CH-1:0]     expire_o
);

   logic [CNTR_WIDTH-1:0] cntr_q [NUM_CH];
   logic [CNTR_WIDTH-1:0] cntr_d [NUM_CH];
   logic [CNTR_WIDTH-1:0] dec    [NUM_CH];
   logic [NUM_CH-1:0]     hit;
   logic [NUM_CH-1:0]     expire_d;
   logic [NUM_CH-1:0]     expire_q;

   // Per-channel next value: clear > overwrite load > max-merge load > decrement.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         dec[c]      = cntr_q[c];
         cntr_d[c]   = cntr_q[c];
         expire_d[c] = 1'b0;
         hit[c]      = 1'b0;
         if ((cntr_q[c] != '0) && !freeze_i) begin
            dec[c] = cntr_q[c] - CNTR_WIDTH'(1);
         end
         // Indices >= NUM_CH never match any channel, so out-of-range loads are dropped.
         hit[c] = load_valid_i & (load_bcast_i | (load_ch_i == CH_W'(c)));
         if (clear_i) begin
            cntr_d[c] = '0;
         end else if (hit[c] && !load_max_i) begin
            cntr_d[c] = load_value_i;
         end else if (hit[c]) begin
            // Merge against the already-decremented value.
            cntr_d[c] = (load_value_i > dec[c]) ? load_value_i : dec[c];
         end else begin
            cntr_d[c] = dec[c];
            // Only a natural 1->0 countdown is an expiry.
            expire_d[c] = (cntr_q[c] == CNTR_WIDTH'(1)) && (dec[c] == '0);
         end
      end
   end

   // Counter and expiry state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cntr_q[c] <= '0;
         end
         expire_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            cntr_q[c] <= cntr_d[c];
         end
         expire_q <= expire_d;
      end
   end

   // Outputs are pure decodes of the registered state.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ready_o[c] = (cntr_q[c] == '0);
      end
      busy_o   = ~&ready_o;
      expire_o = expire_q;
   end

`ifdef VPU_TCB_EARLY_ZERO_EN
   // Early zero flag: what ready_o will show after the next edge.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ready_n_o[c] = (cntr_d[c] == '0);
      end
   end
`endif

endmodule
